// File: rtl/cache_request_sequencer.sv
// cache_request_sequencer
// Front-end sequencer for the L2 cache data-structure block. Accepts one trace
// command (opcode + address) per valid/ready handshake, splits the address into
// tag/index, issues a single lookup to storage, waits for completion (bounded
// by timeoutCycles) and keeps read/write/hit/miss statistics. Opcodes 8 (clear)
// and 9 (print) are handled locally.
//
// Optional feature macro: CACHE_STATS_EN
//   defined   : four saturating statistics counters are built.
//   undefined : readCount/writeCount/hitCount/missCount are tied to 0,
//               opcode 8 is a no-op, opcode 9 still pulses statsValid.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   cmdValid/cmdReady       : command handshake
//   cmdCode, cmdAddress     : trace opcode and address
//   lookupValid             : one-cycle lookup request to storage
//   index, addressTag       : set index and tag of the current request
//   read, snoop             : lookup kind (read vs RFO, snoop origin)
//   lookupDone, lookupHit   : storage completion and hit result
//   statsValid              : one-cycle pulse on print command
//   read/write/hit/missCount: statistics counters
//   cmdError                : one-cycle pulse on illegal opcode or timeout
module cache_request_sequencer #(
  parameter int unsigned addressBits   = 32,
  parameter int unsigned indexBits     = 14,
  parameter int unsigned tagBits       = 12,
  parameter int unsigned offsetBits    = 6,
  parameter int unsigned statsWidth    = 32,
  parameter int unsigned timeoutCycles = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmdValid,
  output logic                   cmdReady,
  input  logic [3:0]             cmdCode,
  input  logic [addressBits-1:0] cmdAddress,
  output logic                   lookupValid,
  output logic [indexBits-1:0]   index,
  output logic [tagBits-1:0]     addressTag,
  output logic                   read,
  output logic                   snoop,
  input  logic                   lookupDone,
  input  logic                   lookupHit,
  output logic                   statsValid,
  output logic [statsWidth-1:0]  readCount,
  output logic [statsWidth-1:0]  writeCount,
  output logic [statsWidth-1:0]  hitCount,
  output logic [statsWidth-1:0]  missCount,
  output logic                   cmdError
);

  // Wait counter only needs to reach timeoutCycles-1.
  localparam int unsigned WaitW = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic                   ready_q, ready_d;
  logic                   lookup_valid_q, lookup_valid_d;
  logic [indexBits-1:0]   index_q, index_d;
  logic [tagBits-1:0]     tag_q, tag_d;
  logic                   read_q, read_d;
  logic                   snoop_q, snoop_d;
  logic                   stats_valid_q, stats_valid_d;
  logic                   error_q, error_d;
  logic                   complete_c;
  logic                   clear_c;

  // Byte offset within the line never reaches storage.
  logic unused_offset;
  assign unused_offset = ^cmdAddress[offsetBits-1:0];

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      ready_q        <= 1'b1;
      lookup_valid_q <= 1'b0;
      index_q        <= '0;
      tag_q          <= '0;
      read_q         <= 1'b0;
      snoop_q        <= 1'b0;
      stats_valid_q  <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      ready_q        <= ready_d;
      lookup_valid_q <= lookup_valid_d;
      index_q        <= index_d;
      tag_q          <= tag_d;
      read_q         <= read_d;
      snoop_q        <= snoop_d;
      stats_valid_q  <= stats_valid_d;
      error_q        <= error_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    ready_d        = ready_q;
    lookup_valid_d = 1'b0;
    index_d        = index_q;
    tag_d          = tag_q;
    read_d         = read_q;
    snoop_d        = snoop_q;
    stats_valid_d  = 1'b0;
    error_d        = 1'b0;
    complete_c     = 1'b0;
    clear_c        = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        wait_d  = '0;
        if (cmdValid && ready_q) begin
          case (cmdCode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
              index_d        = cmdAddress[offsetBits+indexBits-1 -: indexBits];
              tag_d          = cmdAddress[addressBits-1 -: tagBits];
              read_d         = (cmdCode != 4'd1);
              snoop_d        = (cmdCode == 4'd3) || (cmdCode == 4'd4);
              lookup_valid_d = 1'b1;
              ready_d        = 1'b0;
              state_d        = ISSUE;
            end
            4'd8:    clear_c       = 1'b1;
            4'd9:    stats_valid_d = 1'b1;
            default: error_d       = 1'b1;
          endcase
        end
      end

      ISSUE: begin
        wait_d = '0;
        if (lookupDone) begin
          complete_c = 1'b1;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (lookupDone) begin
          complete_c = 1'b1;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end else if (wait_q == WaitW'(timeoutCycles - 1)) begin
          // Last permitted wait cycle elapsed without completion.
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign cmdReady    = ready_q;
  assign lookupValid = lookup_valid_q;
  assign index       = index_q;
  assign addressTag  = tag_q;
  assign read        = read_q;
  assign snoop       = snoop_q;
  assign statsValid  = stats_valid_q;
  assign cmdError    = error_q;

`ifdef CACHE_STATS_EN
  logic [statsWidth-1:0] read_cnt_q, write_cnt_q, hit_cnt_q, miss_cnt_q;
  logic                  count_c;

  // Saturating increment: all-ones is sticky.
  function automatic logic [statsWidth-1:0] sat_inc(input logic [statsWidth-1:0] v);
    return (&v) ? v : v + statsWidth'(1);
  endfunction

  assign count_c = complete_c && !snoop_q;

  // Statistics counters; snoop lookups are not counted.
  always_ff @(posedge clock) begin
    if (reset || clear_c) begin
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else if (count_c) begin
      if (read_q) read_cnt_q  <= sat_inc(read_cnt_q);
      else        write_cnt_q <= sat_inc(write_cnt_q);
      if (lookupHit) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else           miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign readCount  = read_cnt_q;
  assign writeCount = write_cnt_q;
  assign hitCount   = hit_cnt_q;
  assign missCount  = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{lookupHit, complete_c, clear_c};

  assign readCount  = '0;
  assign writeCount = '0;
  assign hitCount   = '0;
  assign missCount  = '0;
`endif

endmodule

// File: tb/tb_cache_request_sequencer.sv
// Scoreboard bench for cache_request_sequencer: a driver issues directed and
// random commands and queues the expected DUT events; a monitor pops and
// compares on every lookupValid / statsValid / cmdError pulse.
module tb_cache_request_sequencer;

  localparam int unsigned SW = 4;
  localparam int unsigned TO = 255;

`ifdef CACHE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          cmdValid;
  logic          cmdReady;
  logic [3:0]    cmdCode;
  logic [31:0]   cmdAddress;
  logic          lookupValid;
  logic [13:0]   index;
  logic [11:0]   addressTag;
  logic          read;
  logic          snoop;
  logic          lookupDone;
  logic          lookupHit;
  logic          statsValid;
  logic [SW-1:0] readCount, writeCount, hitCount, missCount;
  logic          cmdError;

  cache_request_sequencer #(
    .addressBits(32), .indexBits(14), .tagBits(12), .offsetBits(6),
    .statsWidth(SW), .timeoutCycles(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdCode(cmdCode), .cmdAddress(cmdAddress),
    .lookupValid(lookupValid), .index(index), .addressTag(addressTag),
    .read(read), .snoop(snoop), .lookupDone(lookupDone), .lookupHit(lookupHit),
    .statsValid(statsValid), .readCount(readCount), .writeCount(writeCount),
    .hitCount(hitCount), .missCount(missCount), .cmdError(cmdError)
  );

  always #5 clock = ~clock;

  // Expected event: 0 = lookup, 1 = stats print, 2 = error.
  typedef struct {
    int          kind;
    int unsigned idx;
    int unsigned tag;
    int unsigned rd;
    int unsigned sn;
    int unsigned rc, wc, hc, mc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference statistics, kept as plain saturating integers.
  int unsigned m_rc, m_wc, m_hc, m_mc;
  localparam int unsigned CntMax = (1 << SW) - 1;

  function automatic void chk(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic int unsigned cexp(input int unsigned v);
    return StatsEn ? v : 0;
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v < CntMax) ? v + 1 : v;
  endfunction

  // Command class from the opcode table: 0 lookup, 1 clear, 2 print, 3 illegal.
  function automatic int cls(input int c);
    if (c <= 4) return 0;
    if (c == 8) return 1;
    if (c == 9) return 2;
    return 3;
  endfunction

  function automatic void model_clear();
    m_rc = 0; m_wc = 0; m_hc = 0; m_mc = 0;
  endfunction

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    int   nev;
    exp_t e;
    nev = int'(lookupValid) + int'(statsValid) + int'(cmdError);
    if (nev > 1) chk("event_overlap", nev, 1);
    if (nev == 1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {29'd0, lookupValid, statsValid, cmdError}, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == 0) begin
          chk("lookup_evt", int'(lookupValid), 1);
          chk("lookup_index", index, e.idx);
          chk("lookup_tag", addressTag, e.tag);
          chk("lookup_read", int'(read), e.rd);
          chk("lookup_snoop", int'(snoop), e.sn);
        end else if (e.kind == 1) begin
          chk("stats_evt", int'(statsValid), 1);
          chk("stats_read", readCount, e.rc);
          chk("stats_write", writeCount, e.wc);
          chk("stats_hit", hitCount, e.hc);
          chk("stats_miss", missCount, e.mc);
        end else begin
          chk("error_evt", int'(cmdError), 1);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmdReady && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (!cmdReady) chk("ready_wait_timeout", 0, 1);
  endtask

  // Issue one command. lat: wait cycles before lookupDone (0 = in ISSUE), -1 = withheld.
  task automatic do_cmd(input int code, input logic [31:0] addr, input int lat, input bit hit);
    exp_t e;
    int   k;
    wait_ready();
    k = cls(code);
    cmdValid   = 1'b1;
    cmdCode    = 4'(code);
    cmdAddress = addr;
    e = '{kind: 0, idx: (addr >> 6) % (1 << 14), tag: addr >> 20,
          rd: (code != 1) ? 1 : 0, sn: (code == 3 || code == 4) ? 1 : 0,
          rc: 0, wc: 0, hc: 0, mc: 0};
    if (k == 0) begin
      exp_q.push_back(e);
      if (lat < 0) begin
        e.kind = 2;
        exp_q.push_back(e);
      end
    end else if (k == 1) begin
      model_clear();
    end else if (k == 2) begin
      e.kind = 1;
      e.rc = cexp(m_rc); e.wc = cexp(m_wc); e.hc = cexp(m_hc); e.mc = cexp(m_mc);
      exp_q.push_back(e);
    end else begin
      e.kind = 2;
      exp_q.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    cmdValid   = 1'b0;
    cmdCode    = 4'($urandom_range(0, 15));
    cmdAddress = $urandom;
    if (k != 0) begin
      chk("local_cmd_ready", int'(cmdReady), 1);
    end else begin
      chk("busy_ready", int'(cmdReady), 0);
      if (lat >= 0) begin
        for (int i = 0; i < lat; i++) begin
          @(negedge clock);
          chk("wait_hold_index", index, e.idx);
          chk("wait_hold_tag", addressTag, e.tag);
        end
        lookupDone = 1'b1;
        lookupHit  = hit;
        @(negedge clock);
        lookupDone = 1'b0;
        lookupHit  = $urandom_range(0, 1);
        if (e.sn == 0) begin
          if (e.rd != 0) m_rc = sat(m_rc); else m_wc = sat(m_wc);
          if (hit) m_hc = sat(m_hc); else m_mc = sat(m_mc);
        end
        chk("ready_after_done", int'(cmdReady), 1);
      end else begin
        int n = 0;
        while (!cmdReady && n < 400) begin
          @(negedge clock);
          n++;
        end
        chk("timeout_length", n, TO + 1);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(cmdReady), 1);
    chk({tag, "_outs"}, {26'd0, lookupValid, read, snoop, statsValid, cmdError, 1'b0}, 0);
    chk({tag, "_index"}, index, 0);
    chk({tag, "_tag"}, addressTag, 0);
    chk({tag, "_counts"}, {readCount, writeCount, hitCount, missCount}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, code, lat;
    reset      = 1'b1;
    cmdValid   = 1'b0;
    cmdCode    = '0;
    cmdAddress = '0;
    lookupDone = 1'b0;
    lookupHit  = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Directed scenarios.
    do_cmd(0, 32'h1234_5678, 0, 1'b1);
    do_cmd(9, 32'h0, 0, 1'b0);
    do_cmd(1, 32'hABCD_EF40, 2, 1'b0);
    do_cmd(4, 32'h0F0F_0F0F, 1, 1'b0);
    do_cmd(9, 32'h0, 0, 1'b0);
    do_cmd(7, 32'h1111_2222, 0, 1'b0);
    do_cmd(9, 32'h0, 0, 1'b0);
    do_cmd(2, 32'h5555_AAAA, -1, 1'b0);
    lookupDone = 1'b1;   // late completion while idle must be ignored
    lookupHit  = 1'b1;
    @(negedge clock);
    lookupDone = 1'b0;
    @(negedge clock);
    do_cmd(9, 32'h0, 0, 1'b0);
    for (int i = 0; i < 16; i++) do_cmd(0, $urandom, 0, 1'b1);
    do_cmd(9, 32'h0, 0, 1'b0);
    do_cmd(8, 32'h0, 0, 1'b0);
    do_cmd(9, 32'h0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      code = $urandom_range(0, 4);
      else if (r < 72) code = 9;
      else if (r < 76) code = 8;
      else             code = $urandom_range(0, 15);
      lat = ($urandom_range(0, 99) < 2) ? -1 : $urandom_range(0, 4);
      do_cmd(code, $urandom, lat, 1'($urandom_range(0, 1)));
    end
    do_cmd(9, 32'h0, 0, 1'b0);

    // Reset during WAIT coinciding with lookupDone.
    wait_ready();
    cmdValid   = 1'b1;
    cmdCode    = 4'd0;
    cmdAddress = 32'hDEAD_BEEF;
    exp_q.push_back('{kind: 0, idx: (32'hDEAD_BEEF >> 6) % (1 << 14), tag: 32'hDEAD_BEEF >> 20,
                      rd: 1, sn: 0, rc: 0, wc: 0, hc: 0, mc: 0});
    @(posedge clock);
    @(negedge clock);
    cmdValid = 1'b0;
    @(negedge clock);
    reset      = 1'b1;
    lookupDone = 1'b1;
    lookupHit  = 1'b1;
    @(negedge clock);
    chk_reset_outputs("wait_reset");
    reset      = 1'b0;
    lookupDone = 1'b0;
    model_clear();
    @(negedge clock);
    do_cmd(9, 32'h0, 0, 1'b0);

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_request_sequencer.md
# cache_request_sequencer

Front-end sequencer for the L2 cache data-structure block. It accepts one trace command at a time (opcode plus 32-bit address) over a valid/ready handshake, splits the address into tag and index, and issues a single lookup to the cache storage. It then waits for completion, records hit/miss and read/write statistics, and handles the clear and print commands locally.

## Interface
Parameters:
- addressBits, 32, trace address width
- indexBits, 14, set-index width (address bits [offsetBits+indexBits-1:offsetBits])
- tagBits, 12, tag width (address bits [addressBits-1:addressBits-tagBits])
- offsetBits, 6, byte offset within a 512-bit line; tagBits+indexBits+offsetBits must equal addressBits
- statsWidth, 32, width of each statistics counter
- timeoutCycles, 255, maximum cycles to wait for lookupDone

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cmdValid  in  1  command present
- cmdReady  out  1  sequencer can accept a command
- cmdCode  in  4  trace opcode
- cmdAddress  in  addressBits  trace address
- lookupValid  out  1  one-cycle lookup request to storage
- index  out  indexBits  set index of the current request
- addressTag  out  tagBits  tag of the current request
- read  out  1  1 = read lookup, 0 = write (read-for-ownership) lookup
- snoop  out  1  lookup originates from opcode 3 or 4
- lookupDone  in  1  storage finished the lookup
- lookupHit  in  1  hit result, valid with lookupDone
- statsValid  out  1  one-cycle pulse on print command
- readCount, writeCount, hitCount, missCount  out  statsWidth each  statistics
- cmdError  out  1  one-cycle pulse on illegal opcode or timeout

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: cmdReady=1. A command is accepted when cmdValid and cmdReady are both high at a rising edge. The sequencer then latches opcode and address.
  - Opcode 0 (read data) or 2 (read instruction): read=1, snoop=0, go to ISSUE.
  - Opcode 1 (write data): read=0, snoop=0, go to ISSUE.
  - Opcode 3 or 4: read=1, snoop=1, go to ISSUE.
  - Opcode 8: clear all four counters, stay in IDLE.
  - Opcode 9: pulse statsValid, stay in IDLE.
  - Any other opcode: pulse cmdError, drop the command, stay in IDLE.
- ISSUE: lookupValid=1 for exactly one cycle, then go to WAIT. If lookupDone is high in this cycle, it completes the request immediately and the next state is IDLE.
- WAIT: hold index, addressTag, read and snoop stable. Count wait cycles.
  - On lookupDone: update statistics, go to IDLE.
  - If the wait count reaches timeoutCycles without lookupDone: pulse cmdError, leave counters unchanged, go to IDLE.
- Statistics are updated only for non-snoop requests:
  - readCount+1 if read, else writeCount+1.
  - hitCount+1 if lookupHit, else missCount+1.
  - Counters saturate at all-ones; they never wrap.
- lookupDone outside ISSUE/WAIT is ignored.

## Timing
- Reset values: state IDLE; cmdReady=1; every other output 0; wait counter 0.
- Reset asserted in any state forces IDLE on the next edge and discards any in-flight request. Counters clear even if a lookupDone arrives in the same cycle.
- Command accepted at edge N: lookupValid is high during cycle N+1.
- Earliest completion is lookupDone in cycle N+1. Counters then show the update and cmdReady is high again from edge N+2, giving a throughput of one lookup every 2 cycles.
- cmdReady is 0 throughout ISSUE and WAIT.
- statsValid and cmdError are high for exactly one cycle, registered.
  - Counter values seen while statsValid is high include all previously completed requests.
- Timeout: cmdError is high in the cycle after the timeoutCycles-th wait cycle, then the sequencer is in IDLE.

## Configuration
- CACHE_STATS_EN defined: the four counters and their saturation logic are built as described.
- CACHE_STATS_EN undefined: readCount, writeCount, hitCount and missCount are tied to 0 and carry no registers.
  - Opcode 8 becomes a no-op.
  - Opcode 9 still pulses statsValid.
  - Handshake, timing and lookup behaviour are unchanged.

## Test plan
- Reset, then opcode 0 with address 0x1234_5678 and lookupDone+lookupHit one cycle after lookupValid -> addressTag=0x123, index=0x1159, read=1; readCount=1, hitCount=1; cmdReady returns 2 cycles after accept.
- Opcode 1, then opcode 4, each answered with a miss -> writeCount=1, missCount=1; the snoop request sets snoop=1 and leaves all counters unchanged.
- Opcode 7 -> one-cycle cmdError pulse, no lookupValid, counters unchanged. Then opcode 9 -> one statsValid pulse.
- Opcode 2 with lookupDone withheld -> cmdError pulse after 255 wait cycles, state IDLE, counters unchanged. A late lookupDone afterwards is ignored.
- Preload readCount to all-ones via a forced run (statsWidth=4, 16 reads) -> readCount stays 0xF. Opcode 8 -> all counters 0.
- Assert reset during WAIT together with lookupDone -> next cycle all outputs at reset values and no counter increment.
